sr_rx_ctrl: RTL and testbench

SR_RX_CTRL -- requirements
Module: sr_rx_ctrl

---
 rtl/sr_rx_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sr_rx_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_rx_ctrl.sv
// sr_rx_ctrl: receive-side controller for an external serial-in/parallel-out
// shift register. It gates incoming serial bits into the shift register,
// counts bits per word, and captures each completed word into a one-deep
// output holding register with a valid/ready handshake. It also tracks
// packet framing (sop/eop), the number of words stored per packet, and
// sticky error flags.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   sop, eop          packet framing pulses
//   bit_strobe/bit_in serial bit stream (bit_in valid when bit_strobe)
//   shift_enable      shift command to the external shift register
//   sr_serial         serial input bit for the shift register
//   sr_parallel       shift register parallel contents
//   word_data/valid   captured word and its "unconsumed" flag
//   word_ready        consumer accepts word_data
//   word_count        words stored in the current packet
//   pkt_done          one-cycle pulse on the first IDLE cycle after a packet
//   err_overflow      sticky: word dropped because holding register was full
//   err_length        sticky: word dropped because PKT_MAX was reached
//   err_partial       sticky: eop arrived with an incomplete word
//   busy              controller is inside a packet (RECV or DONE)
module sr_rx_ctrl #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned PKT_MAX  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sop,
    input  logic                         eop,
    input  logic                         bit_strobe,
    input  logic                         bit_in,
    output logic                         shift_enable,
    output logic                         sr_serial,
    input  logic [NUM_BITS-1:0]          sr_parallel,
    output logic [NUM_BITS-1:0]          word_data,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(PKT_MAX+1)-1:0] word_count,
    output logic                         pkt_done,
    output logic                         err_overflow,
    output logic                         err_length,
    output logic                         err_partial,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(PKT_MAX + 1);
    localparam int unsigned BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(PKT_MAX);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_cnt_post;
    logic          capture_pending;
    logic          strobe_acc;
    logic          bit_wrap;
    logic          capture_load;

    // Strobes only count while receiving; reset masks the shift command
    // combinationally so nothing reaches the shift register during rst.
    assign strobe_acc   = bit_strobe && (state == RECV);
    assign bit_wrap     = strobe_acc && (bit_cnt == BIT_LAST);
    assign shift_enable = strobe_acc && !rst;
    assign sr_serial    = bit_in;
    assign busy         = (state != IDLE);

    // Bit count after this cycle's strobe; eop is judged against this value
    // so a strobe arriving with eop is counted first.
    always_comb begin
        bit_cnt_post = bit_cnt;
        if (strobe_acc) begin
            bit_cnt_post = bit_wrap ? '0 : bit_cnt + 1'b1;
        end
    end

    // The shift register is updated by the edge ending the last strobe, so
    // sr_parallel is sampled one cycle later (the pending cycle). A strobe in
    // that cycle shifts on the same edge and cannot disturb the sample.
    assign capture_load = capture_pending && (word_count != CNT_MAX) &&
                          (!word_valid || word_ready);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (sop) state_next = RECV;
            RECV:    if (eop) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt         <= '0;
            capture_pending <= 1'b0;
            word_data       <= '0;
            word_valid      <= 1'b0;
            word_count      <= '0;
            pkt_done        <= 1'b0;
            err_overflow    <= 1'b0;
            err_length      <= 1'b0;
            err_partial     <= 1'b0;
        end else begin
            pkt_done        <= (state == DONE);
            capture_pending <= bit_wrap;
            bit_cnt         <= bit_cnt_post;

            if (capture_load) begin
                word_data  <= sr_parallel;
                word_valid <= 1'b1;
                word_count <= word_count + 1'b1;
            end else begin
                if (word_valid && word_ready) begin
                    word_valid <= 1'b0;
                end
                if (capture_pending) begin
                    // Length limit wins over overflow when both apply.
                    if (word_count == CNT_MAX) begin
                        err_length <= 1'b1;
                    end else begin
                        err_overflow <= 1'b1;
                    end
                end
            end

            if (eop && (state == RECV)) begin
                if (bit_cnt_post != '0) begin
                    err_partial <= 1'b1;
                end
                bit_cnt <= '0;
            end

            if (sop && (state == IDLE)) begin
                bit_cnt         <= '0;
                word_count      <= '0;
                capture_pending <= 1'b0;
                err_overflow    <= 1'b0;
                err_length      <= 1'b0;
                err_partial     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_rx_ctrl.sv
// Directed testbench for sr_rx_ctrl. Two instances share stimulus: u_dut
// with default parameters and u_dut2 with PKT_MAX=2. Each drives its own
// behavioural shift register (MSB-first, shift-left).
module tb_sr_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sop = 1'b0;
    logic       eop = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       bit_in = 1'b0;
    logic       word_ready = 1'b0;

    logic       shift_enable, sr_serial, word_valid, pkt_done;
    logic       err_overflow, err_length, err_partial, busy;
    logic [7:0] word_data;
    logic [6:0] word_count;
    logic [7:0] sr = '0;

    logic       shift_enable2, sr_serial2, word_valid2, pkt_done2;
    logic       err_overflow2, err_length2, err_partial2, busy2;
    logic [7:0] word_data2;
    logic [1:0] word_count2;
    logic [7:0] sr2 = '0;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (shift_enable)  sr  <= {sr[6:0], sr_serial};
        if (shift_enable2) sr2 <= {sr2[6:0], sr_serial2};
    end

    sr_rx_ctrl #(.NUM_BITS(8), .PKT_MAX(64)) u_dut (
        .clk(clk), .rst(rst), .sop(sop), .eop(eop),
        .bit_strobe(bit_strobe), .bit_in(bit_in),
        .shift_enable(shift_enable), .sr_serial(sr_serial),
        .sr_parallel(sr), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .word_count(word_count), .pkt_done(pkt_done),
        .err_overflow(err_overflow), .err_length(err_length),
        .err_partial(err_partial), .busy(busy)
    );

    sr_rx_ctrl #(.NUM_BITS(8), .PKT_MAX(2)) u_dut2 (
        .clk(clk), .rst(rst), .sop(sop), .eop(eop),
        .bit_strobe(bit_strobe), .bit_in(bit_in),
        .shift_enable(shift_enable2), .sr_serial(sr_serial2),
        .sr_parallel(sr2), .word_data(word_data2), .word_valid(word_valid2),
        .word_ready(word_ready), .word_count(word_count2), .pkt_done(pkt_done2),
        .err_overflow(err_overflow2), .err_length(err_length2),
        .err_partial(err_partial2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bit_strobe = 1'b1;
            bit_in     = b[i];
            tick();
        end
        bit_strobe = 1'b0;
        bit_in     = 1'b0;
    endtask

    task automatic pulse_sop();
        sop = 1'b1;
        tick();
        sop = 1'b0;
    endtask

    // eop followed by DONE and the pkt_done cycle.
    task automatic end_pkt();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_count", word_count, 0);
        check("rst_pkt_done", pkt_done, 0);
        rst = 1'b0;

        // Strobe in IDLE is ignored
        bit_strobe = 1'b1;
        #1;
        check("idle_shift_en", shift_enable, 0);
        bit_strobe = 1'b0;
        tick();

        // Single word 0xA5 with consumer ready
        word_ready = 1'b1;
        pulse_sop();
        check("sop_busy", busy, 1);
        bit_strobe = 1'b1;
        #1;
        check("recv_shift_en", shift_enable, 1);
        bit_strobe = 1'b0;
        send_byte(8'hA5);
        check("a5_latency", word_valid, 0);
        tick();
        check("a5_valid", word_valid, 1);
        check("a5_data", word_data, 8'hA5);
        check("a5_count", word_count, 1);
        tick();
        check("a5_consumed", word_valid, 0);
        end_pkt();

        // Overflow: consumer stalled, second word dropped
        word_ready = 1'b0;
        pulse_sop();
        send_byte(8'h3C);
        send_byte(8'hFF);
        tick();
        tick();
        check("ovf_valid", word_valid, 1);
        check("ovf_data", word_data, 8'h3C);
        check("ovf_count", word_count, 1);
        check("ovf_err", err_overflow, 1);
        check("ovf_errlen", err_length, 0);
        word_ready = 1'b1;
        tick();
        check("ovf_drain", word_valid, 0);
        end_pkt();

        // Back-to-back 24 bits, consumer ready; u_dut2 hits PKT_MAX=2
        pulse_sop();
        check("b2b_ovf_cleared", err_overflow, 0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        tick();
        check("b2b_valid", word_valid, 1);
        check("b2b_data", word_data, 8'h56);
        tick();
        check("b2b_count", word_count, 3);
        check("b2b_ovf", err_overflow, 0);
        check("b2b_len", err_length, 0);
        check("len_count", word_count2, 2);
        check("len_err", err_length2, 1);
        check("len_ovf", err_overflow2, 0);
        check("len_data", word_data2, 8'h34);
        end_pkt();
        check("b2b_partial", err_partial, 0);

        // Partial word then eop
        pulse_sop();
        for (int i = 0; i < 5; i++) begin
            bit_strobe = 1'b1;
            bit_in     = 1'b1;
            tick();
        end
        bit_strobe = 1'b0;
        eop = 1'b1;
        tick();
        eop = 1'b0;
        check("part_done_busy", busy, 1);
        check("part_done_pulse0", pkt_done, 0);
        check("part_err", err_partial, 1);
        tick();
        check("part_pkt_done", pkt_done, 1);
        check("part_idle", busy, 0);
        tick();
        check("part_pkt_done_off", pkt_done, 0);
        check("part_err_hold", err_partial, 1);
        check("part_count", word_count, 0);
        check("part_valid", word_valid, 0);

        // eop together with the final strobe: word completes, captured in DONE
        pulse_sop();
        check("eopw_partial_clr", err_partial, 0);
        for (int i = 7; i >= 1; i--) begin
            bit_strobe = 1'b1;
            bit_in     = (i == 7) ? 1'b1 : 1'b0;
            tick();
        end
        bit_strobe = 1'b1;
        bit_in     = 1'b1;
        eop        = 1'b1;
        tick();
        bit_strobe = 1'b0;
        bit_in     = 1'b0;
        eop        = 1'b0;
        check("eopw_done_state", busy, 1);
        tick();
        check("eopw_valid", word_valid, 1);
        check("eopw_data", word_data, 8'h81);
        check("eopw_count", word_count, 1);
        check("eopw_pkt_done", pkt_done, 1);
        check("eopw_partial", err_partial, 0);
        tick();

        // Reset mid-word with a word held
        word_ready = 1'b0;
        pulse_sop();
        send_byte(8'h5A);
        for (int i = 0; i < 3; i++) begin
            bit_strobe = 1'b1;
            bit_in     = 1'b1;
            tick();
        end
        check("mid_valid", word_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_shift_en", shift_enable, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", word_valid, 0);
        check("mid_rst_data", word_data, 0);
        check("mid_rst_count", word_count, 0);
        check("mid_rst_errs", {err_overflow, err_length, err_partial}, 0);
        check("mid_rst_pkt_done", pkt_done, 0);
        #1;
        check("post_rst_shift_en", shift_enable, 0);
        for (int i = 0; i < 9; i++) tick();
        bit_strobe = 1'b0;
        check("post_rst_valid", word_valid, 0);
        check("post_rst_count", word_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
